// File: rtl/green_pkg.sv
// Shared FSM encoding and width/limit helpers for the green interpolation stage
// and its iterative divider.
package green_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    RES,
    OUT
  } state_e;

  function automatic int numWidth(input int pixW, input int wgtW);
    return pixW + wgtW + 2;
  endfunction

  function automatic int denWidth(input int wgtW);
    return wgtW + 1;
  endfunction

  function automatic int cntWidth(input int numW);
    return (numW > 1) ? $clog2(numW) : 1;
  endfunction

  // Saturation bounds of a signed PIX_W+1 green sample.
  function automatic int satHi(input int pixW);
    return (1 << pixW) - 1;
  endfunction

  function automatic int satLo(input int pixW);
    return -(1 << pixW);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle over NUM_W cycles.
// A zero divisor still runs the full count and reports a zero quotient.
module seq_divider
  import green_pkg::*;
#(
  parameter int NUM_W = 22,
  parameter int DEN_W = 9,
  parameter int CNT_W = cntWidth(NUM_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] dividend_i,
  input  logic [DEN_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quotient_o
);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [DEN_W:0]   trial;

  // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quo_q[NUM_W-1]};
    if (trial >= {1'b0, den_q}) begin
      rem_d = DEN_W'(trial - {1'b0, den_q});
      quo_d = {quo_q[NUM_W-2:0], 1'b1};
    end else begin
      rem_d = trial[DEN_W-1:0];
      quo_d = {quo_q[NUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      den_q  <= divisor_i;
      cnt_q  <= CNT_W'(NUM_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = (den_q == '0) ? '0 : quo_q;

endmodule

// File: rtl/green_interp_seq.sv
// Edge-directed green reconstruction: selects Gv, Gh or their weighted blend,
// normalised by a fixed shift or a true divide by (h+v), with valid/ready on both sides.
module green_interp_seq
  import green_pkg::*;
#(
  parameter int PIX_W    = 12,
  parameter int WGT_W    = 8,
  parameter int FRAC     = 8,
  parameter int DIV_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WGT_W-1:0]        h,
  input  logic [WGT_W-1:0]        v,
  input  logic [WGT_W-1:0]        threshold,
  input  logic signed [PIX_W:0]   Gh,
  input  logic signed [PIX_W:0]   Gv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [PIX_W:0]   green,
  output logic [1:0]              dir
);

  localparam int NUM_W = numWidth(PIX_W, WGT_W);
  localparam int DEN_W = denWidth(WGT_W);
  localparam int BL_W  = NUM_W + 1;
  localparam int G_W   = PIX_W + 1;
  localparam int CMP_W = 2 * WGT_W + FRAC + 1;
  localparam logic signed [BL_W-1:0] SAT_HI = BL_W'(satHi(PIX_W));
  localparam logic signed [BL_W-1:0] SAT_LO = BL_W'(satLo(PIX_W));

  state_e                  state_q;
  logic                    inReady_q, outValid_q;
  logic [WGT_W-1:0]        h_q, v_q, thr_q;
  logic signed [PIX_W:0]   gh_q, gv_q, green_q, green_d;
  logic [1:0]              dir_q, dir_d;
  logic [2*WGT_W-1:0]      thrH_q, thrV_q, thrH_d, thrV_d;
  logic signed [NUM_W-1:0] numer_q, numer_d;
  logic signed [BL_W-1:0]  blend;
  logic signed [WGT_W:0]   hS, vS;
  logic [NUM_W-1:0]        divQuot;
  logic                    divDone, divBusy;

  // Weights are zero-extended so the numerator products stay signed.
  assign hS      = {1'b0, h_q};
  assign vS      = {1'b0, v_q};
  assign thrH_d  = (2*WGT_W)'(thr_q) * (2*WGT_W)'(h_q);
  assign thrV_d  = (2*WGT_W)'(thr_q) * (2*WGT_W)'(v_q);
  assign numer_d = NUM_W'(gv_q) * NUM_W'(hS) + NUM_W'(gh_q) * NUM_W'(vS);

  generate
    if (DIV_MODE == 1) begin : gen_div
      logic [NUM_W-1:0] absNum;
      assign absNum = numer_d[NUM_W-1] ? NUM_W'(-numer_d) : NUM_W'(numer_d);

      seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(DEN_W)
      ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (state_q == MUL),
        .dividend_i(absNum),
        .divisor_i (DEN_W'(h_q) + DEN_W'(v_q)),
        .busy_o    (divBusy),
        .done_o    (divDone),
        .quotient_o(divQuot)
      );
    end else begin : gen_shift
      assign divQuot = '0;
      assign divDone = 1'b0;
      assign divBusy = 1'b0;
    end
  endgenerate

  // Divide mode reapplies the numerator sign to the magnitude quotient (truncation toward zero).
  always_comb begin
    if (DIV_MODE == 1) begin
      blend = numer_q[NUM_W-1] ? -$signed({1'b0, divQuot}) : $signed({1'b0, divQuot});
    end else begin
      blend = BL_W'(numer_q >>> FRAC);
    end
  end

  always_comb begin
    dir_d = {CMP_W'(thrH_q) > (CMP_W'(v_q) << FRAC),
             CMP_W'(thrV_q) > (CMP_W'(h_q) << FRAC)};
    green_d = G_W'(blend);
    if (blend > SAT_HI) begin
      green_d = G_W'(SAT_HI);
    end else if (blend < SAT_LO) begin
      green_d = G_W'(SAT_LO);
    end
    case (dir_d)
      2'b10:   green_d = gv_q;
      2'b01:   green_d = gh_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      green_q    <= '0;
      dir_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      thr_q      <= '0;
      gh_q       <= '0;
      gv_q       <= '0;
      thrH_q     <= '0;
      thrV_q     <= '0;
      numer_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            h_q       <= h;
            v_q       <= v;
            thr_q     <= threshold;
            gh_q      <= Gh;
            gv_q      <= Gv;
            inReady_q <= 1'b0;
            state_q   <= MUL;
          end
        end
        MUL: begin
          thrH_q  <= thrH_d;
          thrV_q  <= thrV_d;
          numer_q <= numer_d;
          state_q <= (DIV_MODE == 1) ? DIV : RES;
        end
        DIV: begin
          if (divDone || !divBusy) begin
            state_q <= RES;
          end
        end
        RES: begin
          green_q    <= green_d;
          dir_q      <= dir_d;
          outValid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign green     = green_q;
  assign dir       = dir_q;

endmodule
